fft_host_port: RTL and testbench

//  Host-side driver for the external load/unload port of the radix-4 FFT core.
//  - LOAD: takes one frame of N real samples from a valid/ready stream and writes each

---
 rtl/fft_host_port_pkg.sv | 39 +++
 rtl/fft_host_port_skid_fifo.sv | 63 ++++++
 rtl/fft_host_port.sv | 221 ++++++++++++++++++++++
 tb/tb_fft_host_port.sv | 331 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fft_host_port_pkg.sv
// Shared constants, FSM encoding and base-4 index helpers for the FFT host port.
// The same digit-sum / digit-reverse functions feed the core's own address generation.
package fft_host_port_pkg;

    localparam int N_LOG4 = 5;
    localparam int IW     = 2 * N_LOG4;
    localparam int N      = 1 << IW;
    localparam int DEF_AW = 9;

    typedef logic [IW-1:0] idx_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_START,
        ST_WAIT,
        ST_UNLOAD
    } state_t;

    // Bank of a sample index: sum of its base-4 digits, mod 4 (2-bit add wraps).
    function automatic logic [1:0] bank_of(input idx_t idx);
        logic [1:0] s;
        s = 2'd0;
        for (int d = 0; d < N_LOG4; d++) begin
            s = s + idx[2*d +: 2];
        end
        return s;
    endfunction

    function automatic idx_t digit_rev4(input idx_t idx);
        idx_t r;
        r = '0;
        for (int d = 0; d < N_LOG4; d++) begin
            r[2*(N_LOG4-1-d) +: 2] = idx[2*d +: 2];
        end
        return r;
    endfunction

endpackage

// File: rtl/fft_host_port_skid_fifo.sv
// Small register FIFO that absorbs bank reads still in flight when the output stalls.
// Head is shown combinationally; data is forced to 0 while empty.
module fft_host_port_skid_fifo #(
    parameter int DEPTH = 3,
    parameter int W     = 18
) (
    input  logic                           iCLK,
    input  logic                           iRESET,
    input  logic [W-1:0]                   iDATA,
    input  logic                           iPUSH,
    input  logic                           iPOP,
    output logic [W-1:0]                   oDATA,
    output logic                           oVALID,
    output logic [$clog2(DEPTH+1)-1:0]     oCOUNT
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok;
    logic          pop_ok;

    always_comb begin
        push_ok  = iPUSH && (count_q != CW'(DEPTH));
        pop_ok   = iPOP && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d = count_q + CW'(push_ok) - CW'(pop_ok);
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= iDATA;
        end
    end

    assign oVALID = (count_q != '0);
    assign oDATA  = oVALID ? mem_q[rd_ptr_q] : '0;
    assign oCOUNT = count_q;

endmodule

// File: rtl/fft_host_port.sv
// Host driver for the radix-4 FFT core: streams a frame into the four banks, kicks the
// core, then reads the spectrum back in natural bin order with lossless backpressure.
module fft_host_port
    import fft_host_port_pkg::*;
#(
    parameter int AW      = DEF_AW,
    parameter int RD_LAT  = 1,
    parameter int DIG_REV = 1
) (
    input  logic          iCLK,
    input  logic          iRESET,
    input  logic [15:0]   iS_DATA,
    input  logic          iS_VALID,
    output logic          oS_READY,
    output logic [16:0]   oM_DATA,
    output logic          oM_VALID,
    input  logic          iM_READY,
    output logic          oM_LAST,
    output logic [15:0]   oDATA,
    output logic [AW-1:0] oADDR_WR_0,
    output logic [AW-1:0] oADDR_WR_1,
    output logic [AW-1:0] oADDR_WR_2,
    output logic [AW-1:0] oADDR_WR_3,
    output logic          oWE_0,
    output logic          oWE_1,
    output logic          oWE_2,
    output logic          oWE_3,
    output logic [AW-1:0] oADDR_RD_0,
    output logic [AW-1:0] oADDR_RD_1,
    output logic [AW-1:0] oADDR_RD_2,
    output logic [AW-1:0] oADDR_RD_3,
    input  logic [16:0]   iDATA_RE_0,
    input  logic [16:0]   iDATA_RE_1,
    input  logic [16:0]   iDATA_RE_2,
    input  logic [16:0]   iDATA_RE_3,
    output logic          oSTART,
    input  logic          iRDY,
    output logic          oBUSY
);

    localparam int   DEPTH    = RD_LAT + 2;
    localparam int   CW       = $clog2(DEPTH + 1);
    localparam idx_t LAST_IDX = idx_t'(N - 1);

    state_t        state_q, state_d;
    idx_t          i_q, i_d;
    idx_t          k_q, k_d;
    logic          issue_done_q, issue_done_d;
    logic [1:0]    wait_cnt_q, wait_cnt_d;

    logic [RD_LAT-1:0] rd_vld_q, rd_vld_d;
    logic [RD_LAT-1:0] rd_last_q, rd_last_d;
    logic [1:0]        rd_bank_q [RD_LAT];
    logic [1:0]        rd_bank_d [RD_LAT];

    logic          load_fire;
    logic [1:0]    wr_bank;
    logic [AW-1:0] wr_addr;
    idx_t          rd_idx;
    logic [1:0]    rd_bank;
    logic [AW-1:0] rd_addr;
    logic          issue;
    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [17:0]   fifo_dout;
    logic          fifo_valid;
    logic          fifo_pop;

    logic [3:0]    we;
    logic [AW-1:0] addr_wr [4];
    logic [AW-1:0] addr_rd [4];
    logic [16:0]   rd_data [4];

    assign load_fire = (state_q == ST_LOAD) && iS_VALID;
    assign wr_bank   = bank_of(i_q);
    assign wr_addr   = AW'(i_q >> 2);
    assign rd_idx    = (DIG_REV != 0) ? digit_rev4(k_q) : k_q;
    assign rd_bank   = bank_of(rd_idx);
    assign rd_addr   = AW'(rd_idx >> 2);

    always_comb begin
        inflight = '0;
        for (int s = 0; s < RD_LAT; s++) begin
            inflight = inflight + CW'(rd_vld_q[s]);
        end
    end

    // A new read may go out only if every read already in flight still has a slot.
    assign issue = (state_q == ST_UNLOAD) && !issue_done_q
                   && ((CW'(DEPTH) - fifo_count) > inflight);

    assign rd_data[0] = iDATA_RE_0;
    assign rd_data[1] = iDATA_RE_1;
    assign rd_data[2] = iDATA_RE_2;
    assign rd_data[3] = iDATA_RE_3;

    for (genvar gi = 0; gi < 4; gi++) begin : g_bank
        assign we[gi]      = load_fire && (wr_bank == 2'(gi));
        assign addr_wr[gi] = we[gi] ? wr_addr : '0;
        assign addr_rd[gi] = (issue && (rd_bank == 2'(gi))) ? rd_addr : '0;
    end

    assign rd_vld_d[0]  = issue;
    assign rd_last_d[0] = (k_q == LAST_IDX);
    assign rd_bank_d[0] = rd_bank;
    for (genvar gi = 1; gi < RD_LAT; gi++) begin : g_pipe
        assign rd_vld_d[gi]  = rd_vld_q[gi-1];
        assign rd_last_d[gi] = rd_last_q[gi-1];
        assign rd_bank_d[gi] = rd_bank_q[gi-1];
    end

    fft_host_port_skid_fifo #(
        .DEPTH (DEPTH),
        .W     (18)
    ) u_skid (
        .iCLK   (iCLK),
        .iRESET (iRESET),
        .iDATA  ({rd_last_q[RD_LAT-1], rd_data[rd_bank_q[RD_LAT-1]]}),
        .iPUSH  (rd_vld_q[RD_LAT-1]),
        .iPOP   (fifo_pop),
        .oDATA  (fifo_dout),
        .oVALID (fifo_valid),
        .oCOUNT (fifo_count)
    );

    assign fifo_pop = fifo_valid && iM_READY;

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        k_d          = k_q;
        issue_done_d = issue_done_q;
        wait_cnt_d   = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                i_d          = '0;
                k_d          = '0;
                issue_done_d = 1'b0;
                wait_cnt_d   = 2'd0;
                if (iS_VALID) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_fire) begin
                    i_d = i_q + 1'b1;
                    if (i_q == LAST_IDX) begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                wait_cnt_d = 2'd0;
                state_d    = ST_WAIT;
            end
            ST_WAIT: begin
                // The core may still be showing ready from the previous frame.
                if (wait_cnt_q < 2'd2) begin
                    wait_cnt_d = wait_cnt_q + 2'd1;
                end else if (iRDY) begin
                    state_d = ST_UNLOAD;
                end
            end
            ST_UNLOAD: begin
                if (issue) begin
                    k_d = k_q + 1'b1;
                    if (k_q == LAST_IDX) begin
                        issue_done_d = 1'b1;
                    end
                end
                if (fifo_pop && fifo_dout[17]) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (iRESET) begin
            state_q      <= ST_IDLE;
            i_q          <= '0;
            k_q          <= '0;
            issue_done_q <= 1'b0;
            wait_cnt_q   <= 2'd0;
            rd_vld_q     <= '0;
            rd_last_q    <= '0;
            rd_bank_q    <= '{default: 2'd0};
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            k_q          <= k_d;
            issue_done_q <= issue_done_d;
            wait_cnt_q   <= wait_cnt_d;
            rd_vld_q     <= rd_vld_d;
            rd_last_q    <= rd_last_d;
            rd_bank_q    <= rd_bank_d;
        end
    end

    assign oS_READY   = (state_q == ST_LOAD);
    assign oSTART     = (state_q == ST_START);
    assign oBUSY      = (state_q != ST_IDLE);
    assign oDATA      = load_fire ? iS_DATA : '0;
    assign oWE_0      = we[0];
    assign oWE_1      = we[1];
    assign oWE_2      = we[2];
    assign oWE_3      = we[3];
    assign oADDR_WR_0 = addr_wr[0];
    assign oADDR_WR_1 = addr_wr[1];
    assign oADDR_WR_2 = addr_wr[2];
    assign oADDR_WR_3 = addr_wr[3];
    assign oADDR_RD_0 = addr_rd[0];
    assign oADDR_RD_1 = addr_rd[1];
    assign oADDR_RD_2 = addr_rd[2];
    assign oADDR_RD_3 = addr_rd[3];
    assign oM_VALID   = fifo_valid;
    assign oM_DATA    = fifo_dout[16:0];
    assign oM_LAST    = fifo_dout[17];

endmodule

// File: tb/tb_fft_host_port.sv
// Randomised frame-level bench: core bank model, behavioural index map and output scoreboard.
module tb_fft_host_port;

    localparam int NL = 5;
    localparam int N  = 1024;
    localparam int AW = 9;

    logic          clk = 1'b0;
    logic          iRESET = 1'b1;
    logic [15:0]   iS_DATA = '0;
    logic          iS_VALID = 1'b0;
    logic          oS_READY;
    logic [16:0]   oM_DATA;
    logic          oM_VALID;
    logic          iM_READY = 1'b0;
    logic          oM_LAST;
    logic [15:0]   oDATA;
    logic [AW-1:0] oADDR_WR_0, oADDR_WR_1, oADDR_WR_2, oADDR_WR_3;
    logic          oWE_0, oWE_1, oWE_2, oWE_3;
    logic [AW-1:0] oADDR_RD_0, oADDR_RD_1, oADDR_RD_2, oADDR_RD_3;
    logic [16:0]   rd0 = '0, rd1 = '0, rd2 = '0, rd3 = '0;
    logic          oSTART;
    logic          iRDY = 1'b1;
    logic          oBUSY;

    fft_host_port #(.AW(AW), .RD_LAT(1), .DIG_REV(1)) dut (
        .iCLK(clk), .iRESET(iRESET),
        .iS_DATA(iS_DATA), .iS_VALID(iS_VALID), .oS_READY(oS_READY),
        .oM_DATA(oM_DATA), .oM_VALID(oM_VALID), .iM_READY(iM_READY), .oM_LAST(oM_LAST),
        .oDATA(oDATA),
        .oADDR_WR_0(oADDR_WR_0), .oADDR_WR_1(oADDR_WR_1),
        .oADDR_WR_2(oADDR_WR_2), .oADDR_WR_3(oADDR_WR_3),
        .oWE_0(oWE_0), .oWE_1(oWE_1), .oWE_2(oWE_2), .oWE_3(oWE_3),
        .oADDR_RD_0(oADDR_RD_0), .oADDR_RD_1(oADDR_RD_1),
        .oADDR_RD_2(oADDR_RD_2), .oADDR_RD_3(oADDR_RD_3),
        .iDATA_RE_0(rd0), .iDATA_RE_1(rd1), .iDATA_RE_2(rd2), .iDATA_RE_3(rd3),
        .oSTART(oSTART), .iRDY(iRDY), .oBUSY(oBUSY)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [15:0] samples [N];
    logic [16:0] exp_res [N];
    logic [15:0] wr_mem  [4][512];
    int          wr_cnt  [4][512];
    logic [16:0] res_mem [4][512];

    int   ld_cnt = 0, rx_cnt = 0, start_cnt = 0, start_cyc = 0;
    int   first_cyc = 0, last_cyc = 0, ready_pct = 100;
    logic rx_first = 1'b0, chk_en = 1'b0, post_load = 1'b0;
    logic prev_stall = 1'b0, prev_last = 1'b0;
    logic [16:0] prev_data = '0, first_data = '0, last_data = '0;

    function automatic int model_bank(input int i);
        int s = 0;
        int x = i;
        for (int d = 0; d < NL; d++) begin
            s = s + x % 4;
            x = x / 4;
        end
        return s % 4;
    endfunction

    function automatic int digrev(input int k);
        int r = 0;
        int x = k;
        for (int d = 0; d < NL; d++) begin
            r = r * 4 + x % 4;
            x = x / 4;
        end
        return r;
    endfunction

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    task automatic finish_run();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    endtask

    task automatic timeout(input string what);
        total++;
        bad++;
        $display("FAIL timeout_%s: event not seen at cycle %0d, expected within bound", what, cyc);
        finish_run();
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial forever begin
        @(posedge clk);
        #1;
        iM_READY = ($urandom_range(0, 99) < ready_pct);
    end

    // Core bank model: one-cycle registered read of the spectrum memory.
    initial forever begin
        @(posedge clk);
        rd0 <= res_mem[0][oADDR_RD_0];
        rd1 <= res_mem[1][oADDR_RD_1];
        rd2 <= res_mem[2][oADDR_RD_2];
        rd3 <= res_mem[3][oADDR_RD_3];
    end

    // Load-side monitor: write port, start pulse, no acceptance after the frame is in.
    initial forever begin
        logic [3:0] we_v;
        int b;
        int a;
        @(negedge clk);
        if (!iRESET) begin
            we_v = {oWE_3, oWE_2, oWE_1, oWE_0};
            check("we_onehot", ($countones(we_v) > 1) ? 1 : 0, 0);
            if (oSTART) begin
                start_cnt++;
                start_cyc = cyc;
            end
            if (post_load) begin
                check("ready_or_we_after_load", (oS_READY || we_v != 4'b0) ? 1 : 0, 0);
            end
            if (we_v != 4'b0) begin
                b = oWE_0 ? 0 : oWE_1 ? 1 : oWE_2 ? 2 : 3;
                a = (b == 0) ? int'(oADDR_WR_0) : (b == 1) ? int'(oADDR_WR_1)
                  : (b == 2) ? int'(oADDR_WR_2) : int'(oADDR_WR_3);
                check("we_handshake", (oS_READY && iS_VALID) ? 1 : 0, 1);
                if (ld_cnt < N) begin
                    check("wr_bank", b, model_bank(ld_cnt));
                    check("wr_addr", a, ld_cnt / 4);
                    check("wr_data", int'(oDATA), int'(samples[ld_cnt]));
                    wr_mem[b][a] = oDATA;
                    wr_cnt[b][a]++;
                end else begin
                    check("extra_write", ld_cnt, N - 1);
                end
                ld_cnt++;
            end
        end
    end

    // Output scoreboard: every valid cycle is compared against the expected bin.
    initial forever begin
        @(negedge clk);
        if (chk_en && !iRESET) begin
            if (prev_stall) begin
                total++;
                if (!oM_VALID || oM_DATA !== prev_data || oM_LAST !== prev_last) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0d d=%0d l=%0d, expected v=1 d=%0d l=%0d",
                             oM_VALID, oM_DATA, oM_LAST, prev_data, prev_last);
                end
            end
            if (oM_VALID) begin
                if (!rx_first) begin
                    rx_first   = 1'b1;
                    first_cyc  = cyc;
                    first_data = oM_DATA;
                end
                if (rx_cnt >= N) begin
                    check("extra_bin", rx_cnt, N - 1);
                end else begin
                    total++;
                    if (oM_DATA !== exp_res[rx_cnt] || oM_LAST !== (rx_cnt == N - 1)) begin
                        bad++;
                        $display("FAIL bin_%0d: got d=%0d l=%0d, expected d=%0d l=%0d",
                                 rx_cnt, oM_DATA, oM_LAST, exp_res[rx_cnt], (rx_cnt == N - 1));
                    end
                    if (iM_READY) begin
                        if (rx_cnt == N - 1) begin
                            last_cyc  = cyc;
                            last_data = oM_DATA;
                        end
                        rx_cnt++;
                    end
                end
            end
            prev_stall = oM_VALID && !iM_READY;
            prev_data  = oM_DATA;
            prev_last  = oM_LAST;
        end
    end

    task automatic send(input logic [15:0] d, input int gap);
        int w = 0;
        iS_VALID = 1'b1;
        iS_DATA  = d;
        @(negedge clk);
        while (!oS_READY) begin
            w++;
            if (w > 50) timeout("s_ready");
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        if (gap > 0) begin
            iS_VALID = 1'b0;
            iS_DATA  = 16'($urandom);
            repeat (gap) @(posedge clk);
            #1;
        end
    endtask

    // mode 0: ramp, pulsed beats, full-rate output; 1: random, 30% ready, valid held
    // after load; 2: reset at bin 500; 3: back-to-back beats, delayed core ready.
    task automatic run_frame(input int mode);
        int w;
        int errs;
        int j;
        ld_cnt = 0; rx_cnt = 0; start_cnt = 0; rx_first = 1'b0; prev_stall = 1'b0;
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 512; a++) begin
                wr_cnt[b][a] = 0;
            end
        end
        for (int k = 0; k < N; k++) begin
            samples[k] = (mode == 0) ? 16'(k) : 16'($urandom);
            exp_res[k] = (mode == 0) ? 17'(k) : 17'($urandom);
        end
        ready_pct = (mode == 1) ? 30 : (mode == 2) ? 70 : 100;
        iRDY   = (mode != 3);
        chk_en = 1'b1;

        for (int i = 0; i < N; i++) begin
            send(samples[i], (mode == 0) ? 1 : (mode == 3) ? 0 : $urandom_range(0, 2));
        end
        iS_VALID  = (mode == 1);
        post_load = 1'b1;

        check("load_count", ld_cnt, N);
        errs = 0;
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < N / 4; a++) begin
                if (wr_cnt[b][a] != 1) errs++;
            end
        end
        check("slots_written_once", errs, 0);
        if (mode == 0) check("sample5_bank2_addr1", int'(wr_mem[2][1]), 5);

        w = 0;
        while (start_cnt == 0) begin
            @(posedge clk);
            #1;
            w++;
            if (w > 50) timeout("start");
        end
        for (int k = 0; k < N; k++) begin
            j = digrev(k);
            res_mem[model_bank(j)][j / 4] = exp_res[k];
        end
        if (mode == 3) begin
            repeat (10) @(posedge clk);
            #1;
            iRDY = 1'b1;
        end

        w = 0;
        while (rx_cnt < ((mode == 2) ? 500 : N)) begin
            @(posedge clk);
            #1;
            w++;
            if (w > 20000) timeout("unload");
        end

        if (mode == 2) begin
            chk_en    = 1'b0;
            post_load = 1'b0;
            iRESET    = 1'b1;
            @(posedge clk);
            #1;
            check("midreset_m_valid", int'(oM_VALID), 0);
            check("midreset_busy", int'(oBUSY), 0);
            check("midreset_s_ready", int'(oS_READY), 0);
            iRESET = 1'b0;
            repeat (3) @(posedge clk);
            #1;
            return;
        end

        iS_VALID  = 1'b0;
        post_load = 1'b0;
        @(negedge clk);
        check("busy_after_frame", int'(oBUSY), 0);
        check("start_pulses", start_cnt, 1);
        check("wait_gap_ok", (first_cyc - start_cyc >= 5) ? 1 : 0, 1);
        if (mode == 0) begin
            check("first_bin_literal", int'(first_data), 0);
            check("last_bin_literal", int'(last_data), 1023);
            check("full_rate_span", last_cyc - first_cyc, N - 1);
        end
        chk_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        for (int b = 0; b < 4; b++) begin
            for (int a = 0; a < 512; a++) begin
                res_mem[b][a] = '0;
                wr_mem[b][a]  = '0;
            end
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_s_ready", int'(oS_READY), 0);
        check("rst_m_valid", int'(oM_VALID), 0);
        check("rst_busy", int'(oBUSY), 0);
        check("rst_start", int'(oSTART), 0);
        check("rst_we", int'({oWE_3, oWE_2, oWE_1, oWE_0}), 0);
        check("rst_rd_addr", int'(oADDR_RD_0 | oADDR_RD_1 | oADDR_RD_2 | oADDR_RD_3), 0);
        iRESET = 1'b0;
        @(posedge clk);
        #1;
        for (int m = 0; m < 4; m++) begin
            run_frame(m);
        end
        finish_run();
    end

endmodule
